// File: rtl/status_frame_pkg.sv
// Shared types and helpers for the status frame transmitter.
// Defining STATUS_FRAME_CHECKSUM_EN adds the trailing checksum state.
package status_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_SEQ,
        ST_LEN,
        ST_PAYLOAD
`ifdef STATUS_FRAME_CHECKSUM_EN
        , ST_CHK
`endif
    } frame_state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    function automatic int frame_len(input int num_ch, input int ch_w);
        return num_ch * ((ch_w + 7) / 8);
    endfunction

endpackage

// File: rtl/status_frame_tx_trigger.sv
// frame_trigger: period timer, change detect and single pending flag feeding one start request.
// No build-time options; STATUS_FRAME_CHECKSUM_EN has no effect here.
module frame_trigger
    import status_frame_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int CH_W          = 8,
    parameter int PERIOD_CYCLES = 5_000_000,
    parameter int CHANGE_TRIG   = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NUM_CH*CH_W-1:0] i_ch_data,
    input  logic [NUM_CH*CH_W-1:0] i_snapshot,
    input  logic                   i_force,
    input  logic                   i_idle,
    output logic                   o_start_req
);

    localparam int TW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = (PERIOD_CYCLES > 0) ? TW'(PERIOD_CYCLES - 1) : '0;

    logic [TW-1:0] r_timer;
    logic          r_pending;
    logic          w_expire;
    logic          w_change;
    logic          w_trigger;

    assign w_expire    = (PERIOD_CYCLES != 0) && (r_timer == TIMER_LAST);
    assign w_change    = (CHANGE_TRIG != 0) && (i_ch_data != i_snapshot);
    assign w_trigger   = i_force || w_expire || w_change;
    assign o_start_req = i_idle && (w_trigger || r_pending);

    // Timer restarts on every frame start so forced frames postpone the periodic one.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_timer   <= '0;
            r_pending <= 1'b0;
        end else begin
            if (o_start_req || w_expire) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end

            if (o_start_req) begin
                r_pending <= 1'b0;
            end else if (w_trigger && !i_idle) begin
                r_pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/status_frame_tx.sv
// status_frame_tx: snapshots NUM_CH channels and streams SYNC, SEQ, LEN, payload over a valid/ready byte port.
// Optional trailing XOR checksum byte when STATUS_FRAME_CHECKSUM_EN is defined.
//   state   | meaning
//   IDLE    | no frame; waits for start request
//   SYNC/SEQ/LEN | header byte presented
//   PAYLOAD | snapshot byte r_idx presented;  CHK | checksum presented
module status_frame_tx
    import status_frame_pkg::*;
#(
    parameter int         NUM_CH        = 4,
    parameter int         CH_W          = 8,
    parameter int         PERIOD_CYCLES = 5_000_000,
    parameter int         CHANGE_TRIG   = 1,
    parameter logic [7:0] SYNC_BYTE     = DEFAULT_SYNC_BYTE
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NUM_CH*CH_W-1:0] i_ch_data,
    input  logic                   i_force,
    output logic                   o_tx_valid,
    input  logic                   i_tx_ready,
    output logic [7:0]             o_tx_byte,
    output logic                   o_busy,
    output logic [7:0]             o_seq
);

    localparam int BPC = (CH_W + 7) / 8;
    localparam int LEN = frame_len(NUM_CH, CH_W);
    localparam int IW  = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [7:0]    LEN_BYTE = 8'(LEN);
    localparam logic [IW-1:0] LAST_IDX = IW'(LEN - 1);

    frame_state_t          r_state;
    logic [IW-1:0]         r_idx;
    logic                  r_tx_valid;
    logic [7:0]            r_tx_byte;
    logic [7:0]            r_seq;
    logic [NUM_CH*CH_W-1:0] r_snap;
`ifdef STATUS_FRAME_CHECKSUM_EN
    logic [7:0]            r_chk;
    logic [7:0]            w_chk_nxt;
`endif

    frame_state_t          w_state_nxt;
    logic [IW-1:0]         w_idx_nxt;
    logic [IW-1:0]         w_next_idx;
    logic                  w_valid_nxt;
    logic [7:0]            w_byte_nxt;
    logic [7:0]            w_seq_nxt;
    logic                  w_accept;
    logic                  w_idle;
    logic                  w_start_req;
    logic [7:0]            w_pay [LEN];

    // Payload byte j: channel j/BPC, zero-extended, most significant byte first.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [BPC*8-1:0] w_ext;
        assign w_ext = (BPC*8)'(r_snap[c*CH_W +: CH_W]);
        for (genvar b = 0; b < BPC; b++) begin : g_byte
            assign w_pay[c*BPC + b] = w_ext[(BPC-1-b)*8 +: 8];
        end
    end

    assign w_idle     = (r_state == ST_IDLE);
    assign w_accept   = r_tx_valid && i_tx_ready;
    assign w_next_idx = r_idx + 1'b1;

    frame_trigger #(
        .NUM_CH        (NUM_CH),
        .CH_W          (CH_W),
        .PERIOD_CYCLES (PERIOD_CYCLES),
        .CHANGE_TRIG   (CHANGE_TRIG)
    ) u_trigger (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_ch_data   (i_ch_data),
        .i_snapshot  (r_snap),
        .i_force     (i_force),
        .i_idle      (w_idle),
        .o_start_req (w_start_req)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_valid_nxt = r_tx_valid;
        w_byte_nxt  = r_tx_byte;
        w_seq_nxt   = r_seq;
`ifdef STATUS_FRAME_CHECKSUM_EN
        w_chk_nxt   = r_chk;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_start_req) begin
                    w_state_nxt = ST_SYNC;
                    w_valid_nxt = 1'b1;
                    w_byte_nxt  = SYNC_BYTE;
                    w_idx_nxt   = '0;
`ifdef STATUS_FRAME_CHECKSUM_EN
                    w_chk_nxt   = '0;
`endif
                end
            end
            ST_SYNC: begin
                if (w_accept) begin
                    w_state_nxt = ST_SEQ;
                    w_byte_nxt  = r_seq;
                end
            end
            ST_SEQ: begin
                if (w_accept) begin
                    w_state_nxt = ST_LEN;
                    w_byte_nxt  = LEN_BYTE;
`ifdef STATUS_FRAME_CHECKSUM_EN
                    w_chk_nxt   = r_chk ^ r_tx_byte;
`endif
                end
            end
            ST_LEN: begin
                if (w_accept) begin
                    w_state_nxt = ST_PAYLOAD;
                    w_byte_nxt  = w_pay[0];
                    w_idx_nxt   = '0;
`ifdef STATUS_FRAME_CHECKSUM_EN
                    w_chk_nxt   = r_chk ^ r_tx_byte;
`endif
                end
            end
            ST_PAYLOAD: begin
                if (w_accept) begin
                    if (r_idx == LAST_IDX) begin
`ifdef STATUS_FRAME_CHECKSUM_EN
                        w_state_nxt = ST_CHK;
                        w_byte_nxt  = r_chk ^ r_tx_byte;
                        w_chk_nxt   = r_chk ^ r_tx_byte;
`else
                        w_state_nxt = ST_IDLE;
                        w_valid_nxt = 1'b0;
                        w_byte_nxt  = '0;
                        w_seq_nxt   = r_seq + 8'd1;
`endif
                    end else begin
                        w_idx_nxt  = w_next_idx;
                        w_byte_nxt = w_pay[w_next_idx];
`ifdef STATUS_FRAME_CHECKSUM_EN
                        w_chk_nxt  = r_chk ^ r_tx_byte;
`endif
                    end
                end
            end
`ifdef STATUS_FRAME_CHECKSUM_EN
            ST_CHK: begin
                if (w_accept) begin
                    w_state_nxt = ST_IDLE;
                    w_valid_nxt = 1'b0;
                    w_byte_nxt  = '0;
                    w_seq_nxt   = r_seq + 8'd1;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b0;
                w_byte_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_tx_valid <= 1'b0;
            r_tx_byte  <= '0;
            r_seq      <= '0;
            r_snap     <= '0;
`ifdef STATUS_FRAME_CHECKSUM_EN
            r_chk      <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_tx_valid <= w_valid_nxt;
            r_tx_byte  <= w_byte_nxt;
            r_seq      <= w_seq_nxt;
`ifdef STATUS_FRAME_CHECKSUM_EN
            r_chk      <= w_chk_nxt;
`endif
            if (w_start_req) begin
                r_snap <= i_ch_data;
            end
        end
    end

    assign o_tx_valid = r_tx_valid;
    assign o_tx_byte  = r_tx_byte;
    assign o_busy     = !w_idle;
    assign o_seq      = r_seq;

endmodule

// File: tb/tb_status_frame_tx.sv
// Scoreboard bench for status_frame_tx: a frame-level model predicts frame starts and byte contents.
module tb_status_frame_tx;

    localparam int NUM_CH = 3;
    localparam int CH_W   = 12;
    localparam int PERIOD = 60;
    localparam int BPC    = (CH_W + 7) / 8;
    localparam int LEN    = NUM_CH * BPC;
    localparam int W      = NUM_CH * CH_W;
`ifdef STATUS_FRAME_CHECKSUM_EN
    localparam int FRAME_BYTES = 3 + LEN + 1;
`else
    localparam int FRAME_BYTES = 3 + LEN;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] ch_data = '0;
    logic         force_req = 1'b0;
    logic         tx_ready = 1'b1;
    logic         tx_valid;
    logic [7:0]   tx_byte;
    logic         busy;
    logic [7:0]   seq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    status_frame_tx #(
        .NUM_CH        (NUM_CH),
        .CH_W          (CH_W),
        .PERIOD_CYCLES (PERIOD),
        .CHANGE_TRIG   (1),
        .SYNC_BYTE     (8'hA5)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_ch_data  (ch_data),
        .i_force    (force_req),
        .o_tx_valid (tx_valid),
        .i_tx_ready (tx_ready),
        .o_tx_byte  (tx_byte),
        .o_busy     (busy),
        .o_seq      (seq)
    );

    // Reference model: bytes left in current frame, pending flag, cycles since last start.
    int           m_rem = 0;
    bit           m_pending = 1'b0;
    int           m_timer = 0;
    logic [W-1:0] m_snap = '0;
    int           m_seq = 0;
    bit           m_live = 1'b0;
    logic [7:0]   exp_q [$];
    int           log_q [$];
    int           starts [$];
    bit           rec_en = 1'b0;
    int           cyc = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    function automatic void push_frame(input logic [W-1:0] d, input int s);
        int chk;
        int v;
        int bt;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(s));
        exp_q.push_back(8'(LEN));
        chk = (s ^ LEN) & 255;
        for (int c = 0; c < NUM_CH; c++) begin
            v = int'((d >> (c * CH_W)) & W'((1 << CH_W) - 1));
            for (int b = BPC - 1; b >= 0; b--) begin
                bt = (v >> (8 * b)) & 255;
                exp_q.push_back(8'(bt));
                chk = chk ^ bt;
            end
        end
`ifdef STATUS_FRAME_CHECKSUM_EN
        exp_q.push_back(8'(chk));
`endif
    endfunction

    always @(posedge clk) begin : model
        bit trig;
        bit start;
        cyc <= cyc + 1;
        if (rst) begin
            m_rem     = 0;
            m_pending = 1'b0;
            m_timer   = 0;
            m_snap    = '0;
            m_seq     = 0;
            m_live    = 1'b1;
            exp_q.delete();
        end else begin
            trig  = force_req || (m_timer == PERIOD - 1) || (ch_data != m_snap);
            start = (m_rem == 0) && (trig || m_pending);
            if (m_rem > 0) begin
                if (trig) m_pending = 1'b1;
                if (tx_ready) begin
                    m_rem--;
                    if (m_rem == 0) m_seq = (m_seq + 1) % 256;
                end
            end else if (start) begin
                push_frame(ch_data, m_seq);
                m_snap    = ch_data;
                m_rem     = FRAME_BYTES;
                m_pending = 1'b0;
            end
            m_timer = (start || m_timer == PERIOD - 1) ? 0 : m_timer + 1;
        end
    end

    // Monitor: all output comparisons happen at the falling edge.
    logic [7:0] prev_byte = '0;
    bit         prev_stall = 1'b0;
    bit         prev_valid = 1'b0;

    always @(negedge clk) begin
        if (m_live) begin
            check("tx_valid", int'(tx_valid), int'(m_rem > 0));
            check("busy", int'(busy), int'(m_rem > 0));
            check("seq", int'(seq), m_seq);
            if (prev_stall) check("hold_byte", int'(tx_byte), int'(prev_byte));
            if (tx_valid && tx_ready && !rst) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL byte_unexpected actual=%0h required=none at cycle %0d", tx_byte, cyc);
                end else begin
                    check("byte", int'(tx_byte), int'(exp_q.pop_front()));
                end
                log_q.push_back(int'(tx_byte));
            end
            if (rec_en && tx_valid && !prev_valid) starts.push_back(cyc);
            prev_stall = tx_valid && !tx_ready && !rst;
            prev_byte  = tx_byte;
            prev_valid = tx_valid;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input string name);
        bit found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (m_rem == 0 && !m_pending) found = 1'b1;
            else step(1);
        end
        check(name, int'(found), 1);
    endtask

    function automatic logic [W-1:0] rand_ch();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[W-1:0];
    endfunction

    logic [7:0] ka [10] = '{8'hA5, 8'h00, 8'h06, 8'h0A, 8'hBC, 8'h00, 8'h00, 8'h00, 8'h00, 8'hB0};
    bit         pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        bit found;
        ch_data   = W'(36'h000000ABC);
        rst       = 1'b1;
        force_req = 1'b0;
        tx_ready  = 1'b1;
        step(3);
        rst = 1'b0;
        step(20);
        for (int i = 0; i < FRAME_BYTES; i++)
            check("known_byte", (i < log_q.size()) ? log_q[i] : -1, int'(ka[i]));

        for (int i = 0; i < 2000; i++) begin
            tx_ready  = ($urandom_range(0, 9) < 7);
            force_req = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 49) == 0) ch_data = rand_ch();
            step(1);
        end
        force_req = 1'b0;
        tx_ready  = 1'b1;

        wait_idle("idle_before_burst");
        force_req = 1'b1; step(1); force_req = 1'b0; step(2);
        for (int k = 0; k < 3; k++) begin
            force_req = 1'b1; step(1); force_req = 1'b0; step(1);
        end
        step(40);

        wait_idle("idle_before_stall");
        for (int i = 0; i < 48; i++) begin
            force_req = (i == 0);
            tx_ready  = pat[i % 4];
            step(1);
        end
        force_req = 1'b0;
        tx_ready  = 1'b1;

        ch_data = rand_ch();
        step(60);
        rec_en = 1'b1;
        step(330);
        rec_en = 1'b0;
        check("period_count", int'(starts.size() >= 4), 1);
        for (int i = 1; i < starts.size(); i++)
            check("period_gap", starts[i] - starts[i-1], PERIOD);

        wait_idle("idle_before_reset");
        force_req = 1'b1; step(1); force_req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_rem == FRAME_BYTES - 2) found = 1'b1;
            else step(1);
        end
        check("reached_len", int'(found), 1);
        rst = 1'b1; step(1); rst = 1'b0;
        check("rst_valid", int'(tx_valid), 0);
        check("rst_seq", int'(seq), 0);
        force_req = 1'b1; step(1); force_req = 1'b0;
        step(30);

        wait_idle("idle_final");
        check("drain_queue", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
